// File: rtl/ex_mem_if.sv
// EX->MEM stream bundle: EX-side payload/handshake and MEM-side held outputs.
// slave  = the pipeline stage view, master = the surrounding EX/MEM view.
interface ex_mem_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  ex_valid_i;
  logic                  ex_ready_o;
  logic [XLEN-1:0]       alu_result_i;
  logic                  alu_zero_i;
  logic [XLEN-1:0]       store_data_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  reg_write_i;
  logic                  mem_read_i;
  logic                  mem_write_i;
  logic                  is_branch_i;
  logic [2:0]            funct3_i;
  logic [XLEN-1:0]       branch_tgt_i;
  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic [XLEN-1:0]       mem_result_o;
  logic [XLEN-1:0]       mem_store_o;
  logic [REG_ADDR_W-1:0] mem_rd_o;
  logic                  mem_we_o;
  logic                  mem_rd_en_o;
  logic                  mem_wr_en_o;

  modport slave (
    input  ex_valid_i, alu_result_i, alu_zero_i, store_data_i, rd_addr_i,
           reg_write_i, mem_read_i, mem_write_i, is_branch_i, funct3_i,
           branch_tgt_i, mem_ready_i,
    output ex_ready_o, mem_valid_o, mem_result_o, mem_store_o, mem_rd_o,
           mem_we_o, mem_rd_en_o, mem_wr_en_o
  );

  modport master (
    output ex_valid_i, alu_result_i, alu_zero_i, store_data_i, rd_addr_i,
           reg_write_i, mem_read_i, mem_write_i, is_branch_i, funct3_i,
           branch_tgt_i, mem_ready_i,
    input  ex_ready_o, mem_valid_o, mem_result_o, mem_store_o, mem_rd_o,
           mem_we_o, mem_rd_en_o, mem_wr_en_o
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with branch resolution and valid/ready output.
// Build option EXMEM_SKID_EN: adds a skid entry so ex_ready_o comes from a flop
// (full throughput, no mem_ready_i->ex_ready_o path). Undefined: single entry.
module ex_mem_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  ex_mem_if.slave         bus,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [XLEN-1:0]       store;
    logic [REG_ADDR_W-1:0] rd;
    logic                  we;
    logic                  rd_en;
    logic                  wr_en;
  } entry_t;

  entry_t          in_entry;
  logic            taken;
  logic            ex_ready;
  logic            accept;
  logic            pop;

  entry_t          main_q, main_d;
  logic            main_valid_q, main_valid_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
`ifdef EXMEM_SKID_EN
  entry_t          skid_q, skid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            ready_q, ready_d;
`endif

  // Branch condition from ALU flags; incoming entry with branch write-back suppressed
  always_comb begin
    taken = 1'b0;
    case (bus.funct3_i)
      3'b000:          taken = bus.alu_zero_i;
      3'b001:          taken = !bus.alu_zero_i;
      3'b100, 3'b110:  taken = bus.alu_result_i[0];
      3'b101, 3'b111:  taken = !bus.alu_result_i[0];
      default:         taken = 1'b0;
    endcase
    in_entry.result = bus.alu_result_i;
    in_entry.store  = bus.store_data_i;
    in_entry.rd     = bus.rd_addr_i;
    in_entry.we     = bus.reg_write_i && !bus.is_branch_i;
    in_entry.rd_en  = bus.mem_read_i;
    in_entry.wr_en  = bus.mem_write_i;
  end

  // Handshakes on both sides
  always_comb begin
`ifdef EXMEM_SKID_EN
    ex_ready = ready_q;
`else
    ex_ready = !main_valid_q || bus.mem_ready_i;
`endif
    accept = bus.ex_valid_i && ex_ready && !flush_i;
    pop    = main_valid_q && bus.mem_ready_i;
  end

  // Entry occupancy: flush beats everything; skid (if present) refills main on pop
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
`ifdef EXMEM_SKID_EN
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
`endif
    if (flush_i) begin
      main_valid_d = 1'b0;
`ifdef EXMEM_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else if (!main_valid_q || pop) begin
`ifdef EXMEM_SKID_EN
      // skid is only ever occupied behind a full main, and then ready is low
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_entry;
      end
`else
      main_valid_d = accept;
      if (accept) main_d = in_entry;
`endif
    end
`ifdef EXMEM_SKID_EN
    else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
    ready_d = !skid_valid_d;
`endif
  end

  // Redirect pulse for the cycle after a taken branch is accepted; target is sticky
  always_comb begin
    redirect_d    = accept && bus.is_branch_i && taken;
    redirect_pc_d = redirect_d ? bus.branch_tgt_i : redirect_pc_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q        <= '0;
      main_valid_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
`ifdef EXMEM_SKID_EN
      skid_q        <= '0;
      skid_valid_q  <= 1'b0;
      ready_q       <= 1'b1;
`endif
    end else begin
      main_q        <= main_d;
      main_valid_q  <= main_valid_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
`ifdef EXMEM_SKID_EN
      skid_q        <= skid_d;
      skid_valid_q  <= skid_valid_d;
      ready_q       <= ready_d;
`endif
    end
  end

  // Output mapping
  always_comb begin
    bus.ex_ready_o   = ex_ready;
    bus.mem_valid_o  = main_valid_q;
    bus.mem_result_o = main_q.result;
    bus.mem_store_o  = main_q.store;
    bus.mem_rd_o     = main_q.rd;
    bus.mem_we_o     = main_q.we;
    bus.mem_rd_en_o  = main_q.rd_en;
    bus.mem_wr_en_o  = main_q.wr_en;
    redirect_o       = redirect_q;
    redirect_pc_o    = redirect_pc_q;
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage (either EXMEM_SKID_EN build).
module tb_ex_mem_stage;
  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  ex_mem_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus();

  ex_mem_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .bus          (bus),
    .redirect_o   (redirect),
    .redirect_pc_o(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] st;
    logic [RW-1:0]   rd;
    logic            we;
    logic            rde;
    logic            wre;
  } exp_t;

  exp_t            sb[$];
  int              total = 0;
  int              bad = 0;
  int              stall_left = 0;
  logic            exp_redir = 1'b0;
  logic [XLEN-1:0] exp_pc = '0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] f3, input logic [XLEN-1:0] res,
                                       input logic zero);
    case (f3)
      3'b000: return zero;
      3'b001: return !zero;
      3'b100: return res[0];
      3'b110: return res[0];
      3'b101: return !res[0];
      3'b111: return !res[0];
      default: return 1'b0;
    endcase
  endfunction

  // One clock: check at negedge, update the model at the posedge
  task automatic cycle(output logic acc);
    logic pop;
    exp_t e;
    exp_t f;
    bus.mem_ready_i = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    @(negedge clk);
    check("redirect", 128'(redirect), 128'(exp_redir));
    check("redirect_pc", 128'(redirect_pc), 128'(exp_pc));
    check("mem_valid", 128'(bus.mem_valid_o), 128'(sb.size() != 0));
`ifdef EXMEM_SKID_EN
    check("ex_ready", 128'(bus.ex_ready_o), 128'(sb.size() < 2));
`else
    check("ex_ready", 128'(bus.ex_ready_o), 128'((sb.size() == 0) || bus.mem_ready_i));
`endif
    if (bus.mem_valid_o && sb.size() != 0) begin
      f = sb[0];
      check("entry", 128'({bus.mem_result_o, bus.mem_store_o, bus.mem_rd_o,
                           bus.mem_we_o, bus.mem_rd_en_o, bus.mem_wr_en_o}), 128'(f));
    end
    acc = rst_n && bus.ex_valid_i && bus.ex_ready_o && !flush;
    pop = rst_n && bus.mem_valid_o && bus.mem_ready_i;
    e.res = bus.alu_result_i;
    e.st  = bus.store_data_i;
    e.rd  = bus.rd_addr_i;
    e.we  = bus.reg_write_i && !bus.is_branch_i;
    e.rde = bus.mem_read_i;
    e.wre = bus.mem_write_i;
    @(posedge clk);
    if (flush) begin
      sb.delete();
      exp_redir = 1'b0;
    end else begin
      if (pop && sb.size() != 0) void'(sb.pop_front());
      if (acc) sb.push_back(e);
      exp_redir = acc && bus.is_branch_i &&
                  model_taken(bus.funct3_i, bus.alu_result_i, bus.alu_zero_i);
      if (exp_redir) exp_pc = bus.branch_tgt_i;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] res, input logic zero,
                       input logic [XLEN-1:0] st, input logic [RW-1:0] rd, input logic we,
                       input logic mr, input logic mw, input logic br, input logic [2:0] f3,
                       input logic [XLEN-1:0] tgt);
    bus.ex_valid_i   = v;
    bus.alu_result_i = res;
    bus.alu_zero_i   = zero;
    bus.store_data_i = st;
    bus.rd_addr_i    = rd;
    bus.reg_write_i  = we;
    bus.mem_read_i   = mr;
    bus.mem_write_i  = mw;
    bus.is_branch_i  = br;
    bus.funct3_i     = f3;
    bus.branch_tgt_i = tgt;
  endtask

  // Present one instruction and clock until accepted (bounded)
  task automatic send(input logic [XLEN-1:0] res, input logic zero, input logic [XLEN-1:0] st,
                      input logic [RW-1:0] rd, input logic we, input logic mr, input logic mw,
                      input logic br, input logic [2:0] f3, input logic [XLEN-1:0] tgt);
    logic acc;
    int n;
    drive(1'b1, res, zero, st, rd, we, mr, mw, br, f3, tgt);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cycle(acc);
      n++;
    end
    if (!acc) check("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n);
    logic acc;
    bus.ex_valid_i = 1'b0;
    for (int i = 0; i < n; i++) cycle(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, '0);
    bus.mem_ready_i = 1'b1;

    // reset values
    #12;
    check("rst_valid", 128'(bus.mem_valid_o), 128'(0));
    check("rst_ready", 128'(bus.ex_ready_o), 128'(1));
    check("rst_redirect", 128'(redirect), 128'(0));
    check("rst_result", 128'(bus.mem_result_o), 128'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: four ADDs streamed back-to-back
    send(32'h5, 1'b0, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    send(32'h9, 1'b0, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    send(32'hA, 1'b0, 32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0);
    send(32'h0, 1'b1, 32'h44, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    idle(2);

    // 2: BEQ taken, BNE not taken (rd write suppressed on branches)
    send(32'h0, 1'b1, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'h100);
    send(32'h0, 1'b1, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'h180);
    idle(2);

    // 3: BGEU not taken, BLT taken, funct3=010 never taken
    send(32'h1, 1'b0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'b111, 32'h1C0);
    send(32'h1, 1'b0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'b100, 32'h200);
    send(32'h1, 1'b1, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 32'h240);
    send(32'h0, 1'b1, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011, 32'h280);
    idle(2);

    // 4: MEM stalls 3 cycles mid-stream (load/store flags exercised)
    send(32'h1000, 1'b0, 32'hDEAD, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
    stall_left = 3;
    send(32'h1004, 1'b0, 32'hBEEF, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 32'h0);
    send(32'h1008, 1'b0, 32'hCAFE, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0);
    send(32'h100C, 1'b0, 32'hF00D, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    send(32'h1010, 1'b0, 32'h1234, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    idle(3);

    // 5: fill the stage, then flush with a taken branch presented
    stall_left = 10;
    drive(1'b1, 32'h2000, 1'b0, 32'h5, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    for (int i = 0; i < 3; i++) cycle(acc);
    drive(1'b1, 32'h0, 1'b1, 32'h0, 5'd15, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h300);
    flush = 1'b1;
    cycle(acc);
    flush = 1'b0;
    stall_left = 0;
    idle(3);

    // 6: reset during a stall with a taken branch just accepted
    stall_left = 10;
    send(32'h3000, 1'b0, 32'h6, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    send(32'h0, 1'b1, 32'h0, 5'd17, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 32'h400);
    bus.ex_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 128'(bus.mem_valid_o), 128'(0));
    check("arst_redirect", 128'(redirect), 128'(0));
    check("arst_pc", 128'(redirect_pc), 128'(0));
    check("arst_result", 128'(bus.mem_result_o), 128'(0));
    sb.delete();
    exp_redir = 1'b0;
    exp_pc = '0;
    idle(2);
    rst_n = 1'b1;
    stall_left = 0;
    idle(3);
    send(32'h77, 1'b0, 32'h0, 5'd18, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
